lane_draw_ctrl: RTL and testbench
=================================

# lane_draw_ctrl

Sequencer that renders the 10-slot note lane to the VGA adapter once per frame. On a frame tick it snapshots the red/yellow note sequences and rasterises each slot's square pixel by pixel. Each pixel is drawn in the slot's note colour, or in black to erase an empty slot. It sits between the note shifters and the VGA adapter's x/y/colour/plot port, and owns that port exclusively while busy.

## Interface
Parameters:
- NUM_SLOTS, 10, number of lane slots (1..10).
- SQ_SIZE, 4, square edge in pixels (power of two, 2..8).
- X_ORIGIN, 10, x of slot 0's left edge.
- X_PITCH, 10, x distance between slot origins.
- Y_ROW, 112, y of the squares' top edge.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle start pulse, once per frame.
- red_sequence  in  10  bit i = red note in slot i.
- yellow_sequence  in  10  bit i = yellow note in slot i.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour, RGB.
- vga_plot  out  1  pixel write enable.
- busy  out  1  high from LOAD through DONE.
- done  out  1  one-cycle pulse when the pass completes.

## Operation
- States: IDLE, LOAD, DRAW, DONE.
- IDLE → LOAD on frame_tick.
- LOAD:
  - latches both sequences into snapshot registers;
  - clears slot (4 bit) and pix (log2(SQ_SIZE²) bits);
  - → DRAW.
- DRAW, each cycle:
  - vga_plot=1;
  - vga_x = X_ORIGIN + slot·X_PITCH + (pix mod SQ_SIZE);
  - vga_y = Y_ROW + pix / SQ_SIZE.
- Pixel and slot advance:
  - pix increments each DRAW cycle;
  - at pix = SQ_SIZE²−1: if slot = NUM_SLOTS−1 → DONE, else slot+1, pix wraps to 0.
- DONE: done=1 for one cycle → IDLE.
- Colour per slot, from the snapshot bits (red, yellow):
  - 00 → 3'b000 (erase);
  - 10 → 3'b100;
  - 01 → 3'b110;
  - 11 → 3'b010 (green, double note).
- Input changes after LOAD do not affect the current pass.
- frame_tick outside IDLE is ignored; the pass is never restarted.
- frame_tick in the DONE cycle is also ignored.
- Arithmetic:
  - computed at 9 bits, truncated to the port widths;
  - parameters must keep max x ≤ 159 and max y ≤ 119 (elaboration check).
- Outside DRAW: vga_plot=0 and x/y/colour hold their last values.

## Timing
- Reset: state=IDLE, slot=0, pix=0, snapshots=0, all outputs 0.
- Reset in any state takes effect at the next edge. vga_plot drops that cycle, with no partial-pass completion and no done pulse.
- Latency with frame_tick sampled at edge T (default parameters):
  - LOAD during cycle T+1;
  - first plot T+2;
  - 160 plot cycles T+2..T+161;
  - done at T+162;
  - busy high T+1..T+162.
- Outputs derive from registered state and counters only, with no combinational path from inputs. The VGA adapter samples them at the next edge.
- Minimum frame_tick spacing for no overrun: NUM_SLOTS·SQ_SIZE² + 3 cycles.

## Configuration
- LANE_DRAW_OVERRUN_CNT_EN:
  - Defined: adds output overrun_count (8 bit). It increments when frame_tick=1 and state ≠ IDLE, saturates at 255 and clears on reset.
  - Undefined: no port, no counter, and ignored ticks leave no trace.

## Structure
- lane_draw_pkg:
  - state enum (IDLE, LOAD, DRAW, DONE);
  - colour constants BLACK/RED/YELLOW/GREEN/BLUE (3 bit);
  - the (red, yellow) → colour function.
- Sub-module square_raster: pix counter with clear/advance inputs, outputs dx, dy and a last-pixel flag. Instantiated once.

## Test plan
- Reset, then red=10'h001, yellow=10'h200, one frame_tick → exactly 160 plots:
  - slot 0: x 10..13, y 112..115, colour 100;
  - slot 9: x 100..103, colour 110;
  - all other slots colour 000;
  - done at T+162.
- red=yellow=10'h3FF → all 160 plots colour 010. Sequences flipped to 0 at T+5 → colour is unaffected.
- Second frame_tick at T+50 → ignored, still 160 plots, one done. With the macro defined, overrun_count=1.
- Reset asserted at T+80 → vga_plot=0 and busy=0 from T+81, and no done. A new frame_tick completes a full 160-plot pass.
- Back-to-back frame_tick at T+163 → the new pass starts cleanly: LOAD at T+164, first plot at T+165.
- With the macro defined, 300 overlapping ticks → overrun_count saturates at 255.

Source files
------------

// File: rtl/lane_draw_pkg.sv
// rtl/lane_draw_pkg.sv - shared types, colour constants and note colour mapping for the lane renderer
package lane_draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SLOT_W = 4;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;

  // Empty slots are drawn black so that a note leaving a slot gets erased.
  function automatic logic [2:0] note_colour(input logic red, input logic yellow);
    logic [2:0] c;
    case ({red, yellow})
      2'b00:   c = BLACK;
      2'b10:   c = RED;
      2'b01:   c = YELLOW;
      2'b11:   c = GREEN;
      default: c = BLUE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lane_draw_ctrl_square_raster.sv
// rtl/lane_draw_ctrl_square_raster.sv - pixel counter that walks one SQ_SIZE x SQ_SIZE square row by row
module square_raster
  import lane_draw_pkg::*;
#(
  parameter int SQ_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       advance_i,
  output logic [$clog2(SQ_SIZE)-1:0] dx_o,
  output logic [$clog2(SQ_SIZE)-1:0] dy_o,
  output logic                       last_o
);

  localparam int LOG_SQ = $clog2(SQ_SIZE);
  localparam int PIX_W  = 2 * LOG_SQ;

  logic [PIX_W-1:0] pix_q, pix_d;

  // Next pixel index; the power-of-two square lets the counter wrap to 0 on its own.
  always_comb begin
    pix_d = pix_q;
    if (clear_i) begin
      pix_d = '0;
    end else if (advance_i) begin
      pix_d = pix_q + 1'b1;
    end
  end

  // Pixel counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign dx_o   = pix_q[LOG_SQ-1:0];
  assign dy_o   = pix_q[PIX_W-1:LOG_SQ];
  assign last_o = &pix_q;

endmodule

// File: rtl/lane_draw_ctrl.sv
// rtl/lane_draw_ctrl.sv - per-frame lane rasteriser driving the VGA pixel port; LANE_DRAW_OVERRUN_CNT_EN adds overrun_count
module lane_draw_ctrl
  import lane_draw_pkg::*;
#(
  parameter int NUM_SLOTS = 10,
  parameter int SQ_SIZE   = 4,
  parameter int X_ORIGIN  = 10,
  parameter int X_PITCH   = 10,
  parameter int Y_ROW     = 112
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] red_sequence,
  input  logic [9:0] yellow_sequence,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
`ifdef LANE_DRAW_OVERRUN_CNT_EN
  ,
  output logic [7:0] overrun_count
`endif
);

  localparam int LOG_SQ = $clog2(SQ_SIZE);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 10 || SQ_SIZE < 2 || SQ_SIZE > 8 ||
      (1 << LOG_SQ) != SQ_SIZE) begin : g_bad_geometry
    $error("lane_draw_ctrl: NUM_SLOTS or SQ_SIZE out of range");
  end
  if (X_ORIGIN + (NUM_SLOTS - 1) * X_PITCH + SQ_SIZE - 1 > 159 ||
      Y_ROW + SQ_SIZE - 1 > 119) begin : g_bad_extent
    $error("lane_draw_ctrl: lane does not fit on the 160x120 screen");
  end

  state_e state_q, state_d;

  logic [SLOT_W-1:0] slot_q;
  logic [9:0]        red_snap_q, yellow_snap_q;
  logic [7:0]        x_hold_q;
  logic [6:0]        y_hold_q;
  logic [2:0]        colour_hold_q;

  logic              load, plot, last_pix, last_slot;
  logic [LOG_SQ-1:0] dx, dy;
  logic [7:0]        x_live;
  logic [6:0]        y_live;
  logic [2:0]        colour_live;

  square_raster #(.SQ_SIZE(SQ_SIZE)) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (load),
    .advance_i (plot),
    .dx_o      (dx),
    .dy_o      (dy),
    .last_o    (last_pix)
  );

  assign last_slot = (slot_q == SLOT_W'(NUM_SLOTS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a tick is only honoured from IDLE so a pass is never restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick) state_d = LOAD;
      LOAD:    state_d = DRAW;
      DRAW:    if (last_pix && last_slot) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the registered state only.
  always_comb begin
    load = 1'b0;
    plot = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      LOAD:    begin load = 1'b1; busy = 1'b1; end
      DRAW:    begin plot = 1'b1; busy = 1'b1; end
      DONE:    begin done = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Pixel address and colour for the current slot/pixel; screen bounds are checked above so the
  // narrow port widths never truncate a valid coordinate.
  assign x_live      = 8'(X_ORIGIN) + 8'(slot_q) * 8'(X_PITCH) + 8'(dx);
  assign y_live      = 7'(Y_ROW) + 7'(dy);
  assign colour_live = note_colour(red_snap_q[slot_q], yellow_snap_q[slot_q]);

  // Snapshot, slot counter and last-plotted pixel held for the idle port.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q        <= '0;
      red_snap_q    <= '0;
      yellow_snap_q <= '0;
      x_hold_q      <= '0;
      y_hold_q      <= '0;
      colour_hold_q <= '0;
    end else begin
      if (load) begin
        slot_q        <= '0;
        red_snap_q    <= red_sequence;
        yellow_snap_q <= yellow_sequence;
      end
      if (plot) begin
        if (last_pix) slot_q <= slot_q + 1'b1;
        x_hold_q      <= x_live;
        y_hold_q      <= y_live;
        colour_hold_q <= colour_live;
      end
    end
  end

  assign vga_plot   = plot;
  assign vga_x      = plot ? x_live      : x_hold_q;
  assign vga_y      = plot ? y_live      : y_hold_q;
  assign vga_colour = plot ? colour_live : colour_hold_q;

`ifdef LANE_DRAW_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  // Counts ticks that arrive while a pass is in flight, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= '0;
    end else if (frame_tick && state_q != IDLE && overrun_q != 8'hFF) begin
      overrun_q <= overrun_q + 1'b1;
    end
  end

  assign overrun_count = overrun_q;
`endif

endmodule

// File: tb/tb_lane_draw_ctrl.sv
// tb/tb_lane_draw_ctrl.sv - directed table-driven bench for lane_draw_ctrl
module tb_lane_draw_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] red_sequence, yellow_sequence;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;
`ifdef LANE_DRAW_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif

  lane_draw_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .red_sequence    (red_sequence),
    .yellow_sequence (yellow_sequence),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .vga_colour      (vga_colour),
    .vga_plot        (vga_plot),
    .busy            (busy),
    .done            (done)
`ifdef LANE_DRAW_OVERRUN_CNT_EN
    ,
    .overrun_count   (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input logic r, input logic y);
    case ({r, y})
      2'b00:   return 3'b000;
      2'b10:   return 3'b100;
      2'b01:   return 3'b110;
      default: return 3'b010;
    endcase
  endfunction

  typedef struct {
    logic [9:0] red;
    logic [9:0] yel;
    int         tick2_at;
    int         flip_at;
    int         reset_at;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[5];

  // Pulse frame_tick so that it is sampled at the next rising edge (edge T).
  task automatic start_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ep, eb, ed, p, slot, pix, plots, done_seen;
    bit found;

    vecs[0] = '{red: 10'h001, yel: 10'h200, tick2_at: 0,  flip_at: 0, reset_at: 0,  exp_ovr: 0};
    vecs[1] = '{red: 10'h3FF, yel: 10'h3FF, tick2_at: 0,  flip_at: 5, reset_at: 0,  exp_ovr: 0};
    vecs[2] = '{red: 10'h155, yel: 10'h0F0, tick2_at: 50, flip_at: 0, reset_at: 0,  exp_ovr: 1};
    vecs[3] = '{red: 10'h2A5, yel: 10'h3C3, tick2_at: 0,  flip_at: 0, reset_at: 80, exp_ovr: 0};
    vecs[4] = '{red: 10'h0AA, yel: 10'h055, tick2_at: 0,  flip_at: 0, reset_at: 0,  exp_ovr: 0};

    reset = 1'b1;
    frame_tick = 1'b0;
    red_sequence = '0;
    yellow_sequence = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl", {29'b0, vga_plot, busy, done}, 32'd0);
    chk("reset xyc", {14'b0, vga_x, vga_y, vga_colour}, 32'd0);
`ifdef LANE_DRAW_OVERRUN_CNT_EN
    chk("reset overrun", overrun_count, 32'd0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle ctrl", {29'b0, vga_plot, busy, done}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      red_sequence    = vecs[i].red;
      yellow_sequence = vecs[i].yel;
      start_tick();
      for (int k = 1; k <= 166; k++) begin
        @(negedge clk);
        ep = (k >= 2 && k <= 161 && (vecs[i].reset_at == 0 || k <= vecs[i].reset_at)) ? 1 : 0;
        eb = (k >= 1 && k <= 162 && (vecs[i].reset_at == 0 || k <= vecs[i].reset_at)) ? 1 : 0;
        ed = (k == 162 && vecs[i].reset_at == 0) ? 1 : 0;
        chk($sformatf("v%0d k%0d plot/busy/done", i, k),
            {29'b0, vga_plot, busy, done}, 32'(ep * 4 + eb * 2 + ed));
        if (ep == 1) begin
          p = k - 2;
          slot = p / 16;
          pix = p % 16;
          chk($sformatf("v%0d k%0d x", i, k), vga_x, 32'(10 + slot * 10 + pix % 4));
          chk($sformatf("v%0d k%0d y", i, k), vga_y, 32'(112 + pix / 4));
          chk($sformatf("v%0d k%0d colour", i, k), vga_colour,
              32'(exp_colour(vecs[i].red[slot], vecs[i].yel[slot])));
        end else if (k >= 162 && vecs[i].reset_at == 0) begin
          chk($sformatf("v%0d k%0d hold", i, k), {14'b0, vga_x, vga_y, vga_colour},
              {14'b0, 8'd103, 7'd115, exp_colour(vecs[i].red[9], vecs[i].yel[9])});
        end else if (vecs[i].reset_at != 0 && k > vecs[i].reset_at) begin
          chk($sformatf("v%0d k%0d post-reset xyc", i, k), {14'b0, vga_x, vga_y, vga_colour}, 32'd0);
        end
        frame_tick = (k == vecs[i].tick2_at);
        reset      = (k == vecs[i].reset_at);
        if (k == vecs[i].flip_at) begin
          red_sequence    = '0;
          yellow_sequence = '0;
        end
      end
      frame_tick = 1'b0;
      reset = 1'b0;
`ifdef LANE_DRAW_OVERRUN_CNT_EN
      chk($sformatf("v%0d overrun", i), overrun_count, 32'(vecs[i].exp_ovr));
`endif
      repeat (2) @(negedge clk);
    end

    // Tick held across DONE and the following IDLE cycle: only the IDLE one starts a pass.
    red_sequence    = 10'h001;
    yellow_sequence = 10'h000;
    start_tick();
    for (int k = 1; k <= 165; k++) begin
      @(negedge clk);
      if (k == 162) chk("b2b done", done, 32'd1);
      if (k == 163) chk("b2b tick in DONE ignored", busy, 32'd0);
      if (k == 164) chk("b2b LOAD", {30'b0, busy, vga_plot}, 32'd2);
      if (k == 165) begin
        chk("b2b first plot", vga_plot, 32'd1);
        chk("b2b first xyc", {14'b0, vga_x, vga_y, vga_colour},
            {14'b0, 8'd10, 7'd112, 3'b100});
      end
      frame_tick = (k == 162 || k == 163);
    end
    plots = 1;
    done_seen = 0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (vga_plot) plots++;
      if (done) begin
        done_seen++;
        found = 1'b1;
      end
    end
    chk("b2b second pass done", done_seen, 32'd1);
    chk("b2b second pass plots", plots, 32'd160);

`ifdef LANE_DRAW_OVERRUN_CNT_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b1;
    repeat (300) @(negedge clk);
    frame_tick = 1'b0;
    chk("overrun saturates", overrun_count, 32'd255);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    chk("overrun run returns idle", found, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
